// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and Booth digit decode for the sequential multiplier
// Contents: FSM state enum, Booth selection encoding, default operand width,
//           booth_decode() mapping a radix-4 digit {b[i+1], b[i], b[i-1]} to a selection.
package mult_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        SEL_ZERO = 3'd0,
        SEL_POS1 = 3'd1,
        SEL_POS2 = 3'd2,
        SEL_NEG1 = 3'd3,
        SEL_NEG2 = 3'd4
    } sel_t;

    function automatic sel_t booth_decode(input logic [2:0] digit);
        sel_t sel;
        case (digit)
            3'b001, 3'b010: sel = SEL_POS1;
            3'b011:         sel = SEL_POS2;
            3'b100:         sel = SEL_NEG2;
            3'b101, 3'b110: sel = SEL_NEG1;
            default:        sel = SEL_ZERO;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/booth_mult_seq_if.sv
// rtl/booth_mult_seq_if.sv - start/done handshake and operand/result bundle of the multiplier
// Signals: start, a, b (requester -> multiplier); busy, done, hi, lo (multiplier -> requester).
// Modports: master = control unit side, slave = multiplier side.
interface booth_mult_seq_if #(
    parameter int WIDTH = mult_pkg::DEFAULT_WIDTH
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, a, b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, a, b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/booth_digit_sel.sv
// rtl/booth_digit_sel.sv - combinational radix-4 Booth addend selection
// Ports: digit_i  3-bit Booth digit {L[1], L[0], x}
//        m_i      sign-extended multiplicand, WIDTH+2 bits
//        addend_o one of 0, +M, +2M, -M, -2M, WIDTH+2 bits two's complement
module booth_digit_sel
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [2:0]       digit_i,
    input  logic [WIDTH+1:0] m_i,
    output logic [WIDTH+1:0] addend_o
);

    sel_t             sel;
    logic [WIDTH+1:0] mag;

    always_comb begin
        sel = booth_decode(digit_i);
        mag = '0;
        case (sel)
            SEL_POS1, SEL_NEG1: mag = m_i;
            SEL_POS2, SEL_NEG2: mag = {m_i[WIDTH:0], 1'b0};
            default:            mag = '0;
        endcase
        // Two guard bits in M keep 2M and its negation representable for any operand.
        if (sel == SEL_NEG1 || sel == SEL_NEG2) begin
            addend_o = ~mag + 1'b1;
        end else begin
            addend_o = mag;
        end
    end

endmodule

// File: rtl/booth_mult_seq.sv
// rtl/booth_mult_seq.sv - sequential radix-4 Booth signed multiplier, one digit per clock
// Ports: clk   rising-edge clock
//        reset synchronous active-high reset
//        bus   booth_mult_seq_if.slave: start/a/b in, busy/done/hi/lo out
module booth_mult_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    booth_mult_seq_if.slave       bus
);

    localparam int STEPS = WIDTH / 2;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH+1:0] m_q, m_d;
    logic [WIDTH+1:0] u_q, u_d;
    logic [WIDTH-1:0] l_q, l_d;
    logic             x_q, x_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH+1:0] addend;
    logic [WIDTH+1:0] sum;

    booth_digit_sel #(.WIDTH(WIDTH)) u_digit_sel (
        .digit_i  ({l_q[1:0], x_q}),
        .m_i      (m_q),
        .addend_o (addend)
    );

    assign sum = u_q + addend;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            m_q     <= '0;
            u_q     <= '0;
            l_q     <= '0;
            x_q     <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            m_q     <= m_d;
            u_q     <= u_d;
            l_q     <= l_d;
            x_q     <= x_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        m_d     = m_q;
        u_d     = u_q;
        l_d     = l_q;
        x_d     = x_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    m_d     = {{2{bus.a[WIDTH-1]}}, bus.a};
                    u_d     = '0;
                    l_d     = bus.b;
                    x_d     = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Arithmetic right shift by two of {sum, L, x}.
                u_d   = {{2{sum[WIDTH+1]}}, sum[WIDTH+1:2]};
                l_d   = {sum[1:0], l_q[WIDTH-1:2]};
                x_d   = l_q[1];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    // Capture the product on the last step so hi/lo are valid with done.
                    hi_d    = u_d[WIDTH-1:0];
                    lo_d    = l_d;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// tb/tb_booth_mult_seq.sv - self-checking bench for booth_mult_seq
module tb_booth_mult_seq;

    localparam int W     = 32;
    localparam int STEPS = W / 2;

    logic clk;
    logic reset;

    booth_mult_seq_if #(.WIDTH(W)) bus ();

    booth_mult_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: an accepted request at edge N yields busy after edges N..N+STEPS-1,
    // done and the exact signed product after edge N+STEPS, and the next request
    // can be accepted from edge N+STEPS+2 on.
    int                 k        = 0;
    bit                 have_op  = 1'b0;
    int                 op_edge  = 0;
    logic signed [W-1:0]   sa, sb;
    logic signed [2*W-1:0] prod  = '0;
    logic [2*W-1:0]     exp_res  = '0;
    bit                 busy_e   = 1'b0;
    bit                 done_e   = 1'b0;

    always @(posedge clk) begin
        k++;
        if (reset) begin
            have_op = 1'b0;
            exp_res = '0;
            busy_e  = 1'b0;
            done_e  = 1'b0;
        end else begin
            if (have_op && k == op_edge + STEPS) exp_res = prod;
            if (bus.start && (!have_op || k >= op_edge + STEPS + 2)) begin
                have_op = 1'b1;
                op_edge = k;
                sa      = bus.a;
                sb      = bus.b;
                prod    = sa * sb;
            end
            busy_e = have_op && (k - op_edge) < STEPS;
            done_e = have_op && (k == op_edge + STEPS);
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("busy", 64'(bus.busy), 64'(busy_e));
            chk("done", 64'(bus.done), 64'(done_e));
            chk("hi",   64'(bus.hi),   64'(exp_res[2*W-1:W]));
            chk("lo",   64'(bus.lo),   64'(exp_res[W-1:0]));
        end
    end

    task automatic pulse_start(input logic [W-1:0] ia, input logic [W-1:0] ib);
        @(negedge clk);
        bus.a     = ia;
        bus.b     = ib;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic run_op(input string nm, input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic [W-1:0] eh, input logic [W-1:0] el);
        int lat;
        int nbusy;
        pulse_start(ia, ib);
        lat   = -1;
        nbusy = bus.busy ? 1 : 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = i + 1;
                break;
            end
            if (bus.busy) nbusy++;
        end
        chk({nm, "_latency"}, 64'(lat), 64'(STEPS + 1));
        chk({nm, "_busy_cycles"}, 64'(nbusy), 64'(STEPS));
        chk({nm, "_hi"}, 64'(bus.hi), 64'(eh));
        chk({nm, "_lo"}, 64'(bus.lo), 64'(el));
        chk({nm, "_model"}, 64'(prod), {eh, el});
    endtask

    initial begin
        int nd;
        int prev;
        logic [W-1:0] lo_seen;

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(posedge clk);
        checking = 1'b1;
        @(negedge clk);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        chk("reset_hi",   64'(bus.hi),   64'd0);
        chk("reset_lo",   64'(bus.lo),   64'd0);
        reset = 1'b0;

        run_op("10x10",    32'd10,          32'd10,          32'h0000_0000, 32'h0000_0064);
        run_op("m3x7",     32'hFFFF_FFFD,   32'd7,           32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("7xm3",     32'd7,           32'hFFFF_FFFD,   32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("minxmin",  32'h8000_0000,   32'h8000_0000,   32'h4000_0000, 32'h0000_0000);
        run_op("maxxmax",  32'h7FFF_FFFF,   32'h7FFF_FFFF,   32'h3FFF_FFFF, 32'h0000_0001);
        run_op("minxm1",   32'h8000_0000,   32'hFFFF_FFFF,   32'h0000_0000, 32'h8000_0000);

        // Start during RUN is ignored.
        pulse_start(32'd5, 32'd6);
        repeat (3) @(negedge clk);
        bus.a     = 32'd9;
        bus.b     = 32'd9;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        nd      = 0;
        lo_seen = '0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.done) begin
                nd++;
                lo_seen = bus.lo;
            end
        end
        chk("restart_done_count", 64'(nd), 64'd1);
        chk("restart_lo", 64'(lo_seen), 64'd30);
        run_op("9x9", 32'd9, 32'd9, 32'h0, 32'd81);

        // Reset in the middle of RUN aborts the operation.
        pulse_start(32'd100, 32'd100);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_hi",   64'(bus.hi),   64'd0);
        chk("abort_lo",   64'(bus.lo),   64'd0);
        nd = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus.done) nd++;
        end
        chk("abort_no_done", 64'(nd), 64'd0);
        run_op("100x100", 32'd100, 32'd100, 32'h0, 32'h0000_2710);

        // Reset and start on the same edge: reset wins.
        @(negedge clk);
        reset     = 1'b1;
        bus.start = 1'b1;
        bus.a     = 32'd3;
        bus.b     = 32'd3;
        @(negedge clk);
        reset     = 1'b0;
        bus.start = 1'b0;
        chk("reset_vs_start_busy", 64'(bus.busy), 64'd0);
        chk("reset_vs_start_lo",   64'(bus.lo),   64'd0);

        // Back-to-back operations with start held high; operands change every cycle.
        @(negedge clk);
        bus.start = 1'b1;
        nd   = 0;
        prev = -1;
        for (int i = 0; i < 1000 * (STEPS + 2) + 60 && nd < 1000; i++) begin
            @(negedge clk);
            bus.a = ($urandom_range(15) == 0) ? 32'h8000_0000 : W'($urandom);
            bus.b = ($urandom_range(15) == 0) ? 32'h8000_0000 : W'($urandom);
            if (bus.done) begin
                if (prev >= 0) chk("done_spacing", 64'(i - prev), 64'(STEPS + 2));
                prev = i;
                nd++;
            end
        end
        bus.start = 1'b0;
        chk("random_done_count", 64'(nd), 64'd1000);
        repeat (STEPS + 6) @(negedge clk);

        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
